avalon_multi_pio_in: RTL

Parametrised multi-channel input PIO. It is an Avalon-MM slave that exposes NUM_CH external input buses to the HPS/Nios: per-channel synchronised data, edge-capture, interrupt mask and a combined level IRQ. It succeeds the single-channel read-only input port. It adds a metastability synchroniser, edge detection with write-1-to-clear capture, and a CPU interrupt.

---
 rtl/avalon_multi_pio_in.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/avalon_multi_pio_in.sv
// Multi-channel Avalon-MM input PIO: synchronised inputs, sticky edge capture
// with write-1-to-clear, per-channel interrupt mask and a registered level IRQ.
module avalon_multi_pio_in #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 32,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [4:0]               address,
    input  logic                     read,
    input  logic                     write,
    input  logic [31:0]              writedata,
    input  logic                     chipselect,
    input  logic [NUM_CH*DATA_W-1:0] in_port,
    output logic [31:0]              readdata,
    output logic                     irq
);
    localparam int         TOT_W    = NUM_CH * DATA_W;
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_EDGE = 2'd2;

    logic [TOT_W-1:0]  sync_p0;
    logic [TOT_W-1:0]  prev_p1;
    logic [TOT_W-1:0]  det;
    logic [TOT_W-1:0]  clr;
    logic [TOT_W-1:0]  edge_cap;
    logic [TOT_W-1:0]  irq_mask;
    logic [TOT_W-1:0]  pending;
    logic [NUM_CH-1:0] mask_we;
    logic [1:0]        prime_cnt;
    logic              prime;
    logic [2:0]        ch_sel;
    logic [1:0]        reg_sel;
    logic              wr_en;
    logic              rd_en;
    logic [31:0]       rd_val;

    function automatic logic [TOT_W-1:0] edge_detect(input logic [TOT_W-1:0] cur,
                                                     input logic [TOT_W-1:0] old);
        if (EDGE_TYPE == 1)
            return ~cur & old;
        else if (EDGE_TYPE == 2)
            return cur ^ old;
        else
            return cur & ~old;
    endfunction

    // Synchroniser stage boundary
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_p0 = in_port;
        end else begin : g_sync
            logic [TOT_W-1:0] sync_pipe [SYNC_STAGES];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++)
                        sync_pipe[i] <= '0;
                end else begin
                    sync_pipe[0] <= in_port;
                    for (int i = 1; i < SYNC_STAGES; i++)
                        sync_pipe[i] <= sync_pipe[i-1];
                end
            end

            assign sync_p0 = sync_pipe[SYNC_STAGES-1];
        end
    endgenerate

    // Edge-detect stage boundary. prime stays low until both the synchroniser
    // and prev_p1 hold real samples, so the reset-zero flush never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= 2'd0;
            prime     <= 1'b0;
            prev_p1   <= '0;
        end else begin
            if (prime_cnt != 2'(SYNC_STAGES))
                prime_cnt <= prime_cnt + 2'd1;
            prime   <= (prime_cnt == 2'(SYNC_STAGES));
            prev_p1 <= sync_p0;
        end
    end

    assign det = prime ? edge_detect(sync_p0, prev_p1) : '0;

    assign ch_sel  = address[4:2];
    assign reg_sel = address[1:0];
    assign wr_en   = chipselect & write;
    assign rd_en   = chipselect & read;

    // Channels at or above NUM_CH never match, so their writes fall away.
    always_comb begin
        clr     = '0;
        mask_we = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && ch_sel == 3'(c)) begin
                if (reg_sel == REG_EDGE)
                    clr[c*DATA_W +: DATA_W] = writedata[DATA_W-1:0];
                if (reg_sel == REG_MASK)
                    mask_we[c] = 1'b1;
            end
        end
    end

    // Capture / mask stage boundary; a new edge beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
            irq_mask <= '0;
        end else begin
            edge_cap <= (edge_cap & ~clr) | det;
            for (int c = 0; c < NUM_CH; c++) begin
                if (mask_we[c])
                    irq_mask[c*DATA_W +: DATA_W] <= writedata[DATA_W-1:0];
            end
        end
    end

    assign pending = edge_cap & irq_mask;

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == 3'(c)) begin
                case (reg_sel)
                    REG_DATA: rd_val[DATA_W-1:0] = sync_p0[c*DATA_W +: DATA_W];
                    REG_MASK: rd_val[DATA_W-1:0] = irq_mask[c*DATA_W +: DATA_W];
                    REG_EDGE: rd_val[DATA_W-1:0] = edge_cap[c*DATA_W +: DATA_W];
                    default:  rd_val = '0;
                endcase
            end
        end
    end

    // Bus output stage boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (rd_en)
                readdata <= rd_val;
            irq <= |pending;
        end
    end

endmodule
